// File: rtl/ordenador_pkg.sv
// Shared definitions for the sequential sorter.
//   estado_t : controller states (IDLE, LOAD, SORT, OUT, FIM)
//   N_PAD    : default maximum vector length
//   W_PAD    : default element width
//   IDX_W    : index width for the default vector length
package ordenador_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    OUT,
    FIM
  } estado_t;

  localparam int N_PAD = 6;
  localparam int W_PAD = 4;
  localparam int IDX_W = $clog2(N_PAD);

endpackage

// File: rtl/ordenador_cmp_troca.sv
// Combinational compare-swap cell for unsigned operands.
//   a, b  : operands (W bits)
//   lo    : smaller operand (a when equal, keeping the order stable)
//   hi    : larger operand
//   troca : high when a > b, i.e. the pair must be swapped
module ordenador_cmp_troca
  import ordenador_pkg::*;
#(
  parameter int W = W_PAD
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         troca
);

  assign troca = (a > b);
  assign lo    = troca ? b : a;
  assign hi    = troca ? a : b;

endmodule

// File: rtl/ordenador_seq.sv
// Sequential bubble-sort engine.
//   clk, rst    : clock and synchronous active-high reset
//   iniciar/tam : start pulse and run length (clamped to N), IDLE only
//   load_*      : valid/ready stream of input elements, index order
//   out_*       : valid/ready stream of sorted elements, smallest first
//   ocupado     : high whenever the controller is not in IDLE
//   pronto      : one-cycle pulse after the final output handshake
module ordenador_seq
  import ordenador_pkg::*;
#(
  parameter int N = N_PAD,
  parameter int W = W_PAD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iniciar,
  input  logic [2:0]   tam,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  output logic         load_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         ocupado,
  output logic         pronto
);

  // One width covers len (up to N) as well as the k and i indices.
  localparam int CW = $clog2(N + 1);

  estado_t       state_reg, state_next;
  logic [CW-1:0] len_reg, len_next;
  logic [CW-1:0] k_reg, k_next;
  logic [CW-1:0] i_reg, i_next;
  logic          swapped_reg, swapped_next;
  logic [W-1:0]  vet_reg [N];
  logic [W-1:0]  vet_next [N];

  logic [CW-1:0] tam_lim;
  logic [CW-1:0] i_plus1;
  logic [W-1:0]  cmp_a, cmp_b, cmp_lo, cmp_hi, out_mux;
  logic          cmp_troca;
  logic          load_we, swap_we;

  assign i_plus1 = i_reg + CW'(1);
  assign load_we = (state_reg == LOAD) && load_valid;
  assign swap_we = (state_reg == SORT) && cmp_troca;

  always_comb begin
    if (int'(tam) > N) tam_lim = CW'(N);
    else               tam_lim = CW'(tam);
  end

  // Read muxes for the compare pair and the output element.
  always_comb begin
    cmp_a   = '0;
    cmp_b   = '0;
    out_mux = '0;
    for (int j = 0; j < N; j++) begin
      if (i_reg == CW'(j))   cmp_a   = vet_reg[j];
      if (i_plus1 == CW'(j)) cmp_b   = vet_reg[j];
      if (k_reg == CW'(j))   out_mux = vet_reg[j];
    end
  end

  assign out_data = out_mux;

  ordenador_cmp_troca #(.W(W)) u_cmp (
    .a     (cmp_a),
    .b     (cmp_b),
    .lo    (cmp_lo),
    .hi    (cmp_hi),
    .troca (cmp_troca)
  );

  // Per-element next value: a load write or one side of a swap.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_vet
      assign vet_next[gi] = (load_we && k_reg == CW'(gi))   ? load_data :
                            (swap_we && i_reg == CW'(gi))   ? cmp_lo    :
                            (swap_we && i_plus1 == CW'(gi)) ? cmp_hi    :
                                                              vet_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    k_next       = k_reg;
    i_next       = i_reg;
    swapped_next = swapped_reg;
    case (state_reg)
      IDLE: begin
        if (iniciar) begin
          len_next     = tam_lim;
          k_next       = '0;
          i_next       = '0;
          swapped_next = 1'b0;
          state_next   = (tam_lim == '0) ? FIM : LOAD;
        end
      end
      LOAD: begin
        if (load_valid) begin
          if (k_reg == len_reg - CW'(1)) begin
            k_next       = '0;
            i_next       = '0;
            swapped_next = 1'b0;
            // A single element is trivially sorted.
            state_next   = (len_reg == CW'(1)) ? OUT : SORT;
          end else begin
            k_next = k_reg + CW'(1);
          end
        end
      end
      SORT: begin
        if (i_reg == len_reg - CW'(2)) begin
          // End of pass: another pass only if anything moved in this one.
          if (swapped_reg || cmp_troca) begin
            i_next       = '0;
            swapped_next = 1'b0;
          end else begin
            k_next     = '0;
            state_next = OUT;
          end
        end else begin
          i_next       = i_plus1;
          swapped_next = swapped_reg || cmp_troca;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (k_reg == len_reg - CW'(1)) begin
            k_next     = '0;
            state_next = FIM;
          end else begin
            k_next = k_reg + CW'(1);
          end
        end
      end
      FIM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      k_reg       <= '0;
      i_reg       <= '0;
      swapped_reg <= 1'b0;
      for (int j = 0; j < N; j++) vet_reg[j] <= '0;
      load_ready  <= 1'b0;
      out_valid   <= 1'b0;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      k_reg       <= k_next;
      i_reg       <= i_next;
      swapped_reg <= swapped_next;
      vet_reg     <= vet_next;
      // Status outputs are decoded from the next state so they align with it.
      load_ready  <= (state_next == LOAD);
      out_valid   <= (state_next == OUT);
      ocupado     <= (state_next != IDLE);
      pronto      <= (state_next == FIM);
    end
  end

endmodule

// File: tb/tb_ordenador_seq.sv
module tb_ordenador_seq;

  localparam int N = 6;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         iniciar;
  logic [2:0]   tam;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         ocupado;
  logic         pronto;

  int checks   = 0;
  int failures = 0;
  int pronto_cnt = 0;

  logic [W-1:0] din[$];

  ordenador_seq #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .iniciar    (iniciar),
    .tam        (tam),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .ocupado    (ocupado),
    .pronto     (pronto)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pronto) pronto_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap/stall modes: 0 = never, 1 = every other cycle, 2 = random ~30%
  function automatic bit pick(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 1;
    return $urandom_range(0, 99) >= 30;
  endfunction

  task automatic run(input int tam_v, input int gap, input int stall, input bit inject);
    int len, acc, cyc, cnt, r, s_exp, maxinv, inv, p0, pos;
    logic [W-1:0] expq[$];
    bit prev_stall;
    logic [W-1:0] prev_data;

    // Reference: stable ascending order, and pass count from inversions.
    len = (tam_v > N) ? N : tam_v;
    expq = {};
    maxinv = 0;
    for (int j = 0; j < len; j++) begin
      pos = expq.size();
      for (int m = 0; m < expq.size(); m++)
        if (expq[m] > din[j]) begin pos = m; break; end
      expq.insert(pos, din[j]);
      inv = 0;
      for (int m = 0; m < j; m++) if (din[m] > din[j]) inv++;
      if (inv > maxinv) maxinv = inv;
    end
    s_exp = (len >= 2) ? (maxinv + 1) * (len - 1) : 0;
    p0 = pronto_cnt;
    cnt = 0;

    tam = 3'(tam_v);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("ocupado_start", 32'(ocupado), 32'd1);

    if (len == 0) begin
      check("zero_load_ready", 32'(load_ready), 32'd0);
      check("zero_out_valid", 32'(out_valid), 32'd0);
      check("zero_pronto", 32'(pronto), 32'd1);
    end else begin
      acc = 0;
      cyc = 0;
      while (load_ready && cyc < 200) begin
        load_valid = pick(gap, cyc);
        load_data  = (acc < din.size()) ? din[acc] : '0;
        step();
        cyc++;
        if (load_valid) acc++;
      end
      load_valid = 1'b0;
      check("loads_accepted", 32'(acc), 32'(len));

      while (!out_valid && cnt < 200) begin
        if (inject && cnt == 1) begin
          iniciar = 1'b1;
          tam = 3'd2;
        end else begin
          iniciar = 1'b0;
        end
        step();
        cnt++;
      end
      iniciar = 1'b0;
      check("sort_cycles", 32'(cnt), 32'(s_exp));

      r = 0;
      cyc = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      while (r < len && cyc < 400) begin
        out_ready = pick(stall, cyc);
        if (prev_stall) check("hold_out_data", 32'(out_data), 32'(prev_data));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
          check($sformatf("out%0d", r), 32'(out_data), 32'(expq[r]));
          r++;
        end
        step();
        cyc++;
      end
      out_ready = 1'b0;
      check("outputs_count", 32'(r), 32'(len));
      check("pronto_after_last", 32'(pronto), 32'd1);
      check("out_valid_in_fim", 32'(out_valid), 32'd0);
    end

    step();
    check("pronto_one_cycle", 32'(pronto), 32'd0);
    check("ocupado_end", 32'(ocupado), 32'd0);
    check("pronto_pulses", 32'(pronto_cnt - p0), 32'd1);
    if (inject) begin
      repeat (3) step();
      check("no_second_run", 32'(ocupado), 32'd0);
    end
    $display("run tam=%0d len=%0d sort_cycles=%0d expected_sort=%0d", tam_v, len, cnt, s_exp);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    iniciar = 1'b0;
    tam = '0;
    load_valid = 1'b0;
    load_data = '0;
    out_ready = 1'b0;
    repeat (2) step();
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    rst = 1'b0;
    step();

    din = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    run(6, 0, 0, 1'b0);
    din = {4'h1, 4'h2, 4'h2, 4'h3, 4'h9, 4'hF};
    run(6, 0, 0, 1'b0);
    din = {4'h7, 4'h3, 4'h7, 4'h1};
    run(4, 1, 1, 1'b0);
    din = {4'hA};
    run(1, 0, 0, 1'b0);
    din = {};
    run(0, 0, 0, 1'b0);
    din = {};
    for (int j = 0; j < 7; j++) din.push_back(W'($urandom_range(0, 15)));
    run(7, 0, 0, 1'b0);
    din = {4'h9, 4'h2, 4'h8, 4'h1, 4'h5};
    run(5, 0, 0, 1'b1);

    // Reset in the middle of SORT.
    t = pronto_cnt;
    tam = 3'd5;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int j = 0; j < 5; j++) begin
      load_valid = 1'b1;
      load_data  = W'($urandom_range(0, 15));
      step();
    end
    load_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("midrst_load_ready", 32'(load_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_ocupado", 32'(ocupado), 32'd0);
    check("midrst_pronto", 32'(pronto), 32'd0);
    rst = 1'b0;
    step();
    check("midrst_no_pronto", 32'(pronto_cnt - t), 32'd0);
    $display("run reset_mid_sort tam=5");
    din = {4'h2, 4'h0, 4'h1};
    run(3, 0, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      t = $urandom_range(0, 7);
      din = {};
      for (int j = 0; j < t; j++) din.push_back(W'($urandom_range(0, 15)));
      run(t, 2, 2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
